boot_loader: RTL and testbench

//  Byte-stream bootloader upstream of the core's instruction memory. Receives a framed program

---
 rtl/boot_loader_pkg.sv | 29 ++
 rtl/boot_loader.sv | 208 ++++++++++++++++++++
 tb/tb_boot_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_pkg
// Description : Shared encodings for the byte-stream bootloader: loader state
//               codes, frame magic byte and the word-to-byte address helper.
//               Intended to be shared with a host-side loader model.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_loader_pkg;

    // Loader state encoding (3 bits)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    // First byte of every frame
    localparam logic [7:0] BOOT_MAGIC = 8'hB0;

    // Byte address of a 32-bit word: zero-extended index with two zero LSBs
    function automatic logic [31:0] word_byte_addr(input logic [16:0] idx);
        return {13'd0, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Receives a framed program image over a valid/ready byte
//               stream, assembles little-endian 32-bit words, writes them to
//               instruction memory and releases the core from reset once the
//               payload XOR checksum matches.
//               Frame: B0 | N[7:0] | N[15:8] | 4*N payload bytes | XOR
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        boot_req,
    output logic        mem_w_enb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    // Largest word count the instruction memory can hold
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_BITS);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic [15:0] r_len;
    logic [16:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;          // lower three bytes of the word in flight
    logic [7:0]  r_csum;

    logic        r_mem_w_enb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_w_data;

    logic        w_ready_state;
    logic        w_done;
    logic        w_error;
    logic        w_core_rst;

    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_len_too_big;
    logic        w_last_word;
    logic        w_restart;

    // A byte is consumed only when both sides agree on a clock edge
    assign w_accept      = in_valid & in_ready;
    // Full word count as it becomes known while the high byte is presented
    assign w_len_full    = {in_data, r_len[7:0]};
    assign w_len_too_big = {1'b0, w_len_full} > MAX_WORDS;
    // The word completing now is the final one of the image
    assign w_last_word   = (r_word_idx + 17'd1) == {1'b0, r_len};
    // boot_req is honoured only from the terminal states
    assign w_restart     = boot_req & ((r_state == ST_DONE) | (r_state == ST_ERR));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: advance on accepted bytes, restart on boot_req
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (in_data == BOOT_MAGIC)) begin
                    w_next_state = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_accept) begin
                    w_next_state = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_accept) begin
                    if (w_len_too_big) begin
                        w_next_state = ST_ERR;
                    end else if (w_len_full == 16'd0) begin
                        w_next_state = ST_CHECK;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3) && w_last_word) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    w_next_state = (in_data == r_csum) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (boot_req) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs: ready while loading, status flags in terminal states
    always_comb begin
        w_ready_state = 1'b0;
        w_done        = 1'b0;
        w_error       = 1'b0;
        w_core_rst    = 1'b1;
        case (r_state)
            ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: w_ready_state = 1'b1;
            ST_DONE: begin
                w_done     = 1'b1;
                w_core_rst = 1'b0;
            end
            ST_ERR:  w_error = 1'b1;
            default: w_ready_state = 1'b0;
        endcase
    end

    // in_ready is forced low while reset is held, independent of the clock
    assign in_ready = w_ready_state & rst;
    assign done     = w_done;
    assign error    = w_error;
    assign core_rst = w_core_rst;

    // Frame bookkeeping: length capture, checksum and word index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len      <= 16'd0;
            r_csum     <= 8'd0;
            r_word_idx <= 17'd0;
        end else if (w_restart) begin
            r_len      <= 16'd0;
            r_csum     <= 8'd0;
            r_word_idx <= 17'd0;
        end else if (w_accept) begin
            case (r_state)
                ST_LEN_LO: r_len[7:0]  <= in_data;
                ST_LEN_HI: r_len[15:8] <= in_data;
                ST_DATA: begin
                    r_csum <= r_csum ^ in_data;
                    if (r_byte_cnt == 2'd3) begin
                        r_word_idx <= r_word_idx + 17'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word assembly: little-endian byte shifter with a wrapping byte counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 24'd0;
        end else if (w_restart) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 24'd0;
        end else if (w_accept && (r_state == ST_DATA)) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0:    r_word[7:0]   <= in_data;
                2'd1:    r_word[15:8]  <= in_data;
                2'd2:    r_word[23:16] <= in_data;
                default: ;
            endcase
        end
    end

    // Memory write port: one-cycle pulse after a word's 4th byte; addr/data hold between pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_w_enb  <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_w_data <= 32'd0;
        end else begin
            r_mem_w_enb <= 1'b0;
            if (w_accept && (r_state == ST_DATA) && (r_byte_cnt == 2'd3)) begin
                r_mem_w_enb  <= 1'b1;
                r_mem_addr   <= word_byte_addr(r_word_idx);
                r_mem_w_data <= {in_data, r_word};
            end
        end
    end

    assign mem_w_enb  = r_mem_w_enb;
    assign mem_addr   = r_mem_addr;
    assign mem_w_data = r_mem_w_data;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Self-checking bench for boot_loader. Frames are built from a
//               list of words; expected writes and checksum come from that list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;
    import boot_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        boot_req;
    logic        mem_w_enb;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        core_rst;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_words[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          ready_drop = 0;

    boot_loader #(.ADDR_BITS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .boot_req   (boot_req),
        .mem_w_enb  (mem_w_enb),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Record every write pulse seen by instruction memory
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_w_enb === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_w_data);
            if (in_ready !== 1'b1) ready_drop++;
        end
    end

    // Reference checksum: XOR of every payload byte of the image
    function automatic logic [7:0] model_csum();
        logic [7:0] c = 8'h00;
        foreach (exp_words[i]) begin
            logic [31:0] w = exp_words[i];
            c = c ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        return c;
    endfunction

    // Present one byte (called at a negedge); returns at the negedge after acceptance
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic maybe_gap(input int gap_pct);
        if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    // Magic, length and payload of exp_words; the checksum byte is left to the caller
    task automatic send_body(input int gap_pct);
        logic [15:0] n = 16'(exp_words.size());
        maybe_gap(gap_pct); send_byte(BOOT_MAGIC);
        maybe_gap(gap_pct); send_byte(n[7:0]);
        maybe_gap(gap_pct); send_byte(n[15:8]);
        foreach (exp_words[i]) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w = exp_words[i];
                maybe_gap(gap_pct);
                send_byte(w[8*k +: 8]);
            end
        end
        maybe_gap(gap_pct);
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic clear_capture();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; boot_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mem_w_enb, core_rst, done, error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_flags: {rdy,wen,crst,done,err}=%b required 00100",
                     {in_ready, mem_w_enb, core_rst, done, error});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_w_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data=%h required 0/0", mem_addr, mem_w_data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        clear_capture();
        exp_words = '{32'h00500093, 32'h00A00113};
        send_body(0);
        checks++;
        if (core_rst !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pre_csum: core_rst=%b done=%b required 1/0", core_rst, done);
        end
        send_byte(model_csum());
        checks++;
        if (core_rst !== 1'b0 || done !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: crst=%b done=%b err=%b rdy=%b required 0/1/0/0",
                     core_rst, done, error, in_ready);
        end
        checks++;
        if (got_addr.size() != 2) begin
            errors++;
            $display("FAIL basic_count: writes=%0d required 2", got_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_addr[i] !== 32'(i * 4) || got_data[i] !== exp_words[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d: addr=%h data=%h required %h/%h",
                             i, got_addr[i], got_data[i], i * 4, exp_words[i]);
                end
            end
        end
        pulse_boot();
        checks++;
        if (done !== 1'b0 || core_rst !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_restart: done=%b crst=%b rdy=%b required 0/1/1",
                     done, core_rst, in_ready);
        end
    endtask

    task automatic test_garbage();
        clear_capture();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        exp_words = '{32'($urandom())};
        send_body(0);
        send_byte(model_csum());
        checks++;
        if (got_addr.size() != 1 || got_addr[0] !== 32'd0 || got_data[0] !== exp_words[0]
            || done !== 1'b1) begin
            errors++;
            $display("FAIL garbage: writes=%0d done=%b data=%h required 1 write at 0 of %h, done=1",
                     got_addr.size(), done, got_data.size() > 0 ? got_data[0] : 32'hx, exp_words[0]);
        end
        pulse_boot();
    endtask

    task automatic test_bad_csum();
        clear_capture();
        exp_words = '{32'($urandom())};
        send_body(0);
        send_byte(model_csum() ^ 8'h01);
        checks++;
        if (got_addr.size() != 1 || error !== 1'b1 || core_rst !== 1'b1 || in_ready !== 1'b0
            || done !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum: writes=%0d err=%b crst=%b rdy=%b done=%b required 1/1/1/0/0",
                     got_addr.size(), error, core_rst, in_ready, done);
        end
        // boot_req and a byte together: restart, byte must not be consumed
        boot_req = 1'b1; in_valid = 1'b1; in_data = BOOT_MAGIC;
        @(negedge clk);
        boot_req = 1'b0; in_valid = 1'b0;
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_restart: err=%b rdy=%b required 0/1", error, in_ready);
        end
        clear_capture();
        exp_words = '{32'($urandom())};
        send_body(0);
        send_byte(model_csum());
        checks++;
        if (got_addr.size() != 1 || got_data[0] !== exp_words[0] || done !== 1'b1) begin
            errors++;
            $display("FAIL restart_frame: writes=%0d done=%b required 1 write of %h, done=1",
                     got_addr.size(), done, exp_words[0]);
        end
        pulse_boot();
    endtask

    task automatic test_length();
        int bad;
        clear_capture();
        send_byte(BOOT_MAGIC); send_byte(8'h01); send_byte(8'h04);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || got_addr.size() != 0) begin
            errors++;
            $display("FAIL len_too_big: err=%b rdy=%b writes=%0d required 1/0/0",
                     error, in_ready, got_addr.size());
        end
        pulse_boot();
        exp_words.delete();
        send_body(0);
        send_byte(8'h00);
        checks++;
        if (done !== 1'b1 || got_addr.size() != 0) begin
            errors++;
            $display("FAIL len_zero: done=%b writes=%0d required 1/0", done, got_addr.size());
        end
        pulse_boot();
        // Exactly full memory is legal
        exp_words.delete();
        for (int i = 0; i < 1024; i++) exp_words.push_back(32'($urandom()));
        send_body(0);
        send_byte(model_csum());
        checks++;
        if (done !== 1'b1 || got_addr.size() != 1024) begin
            errors++;
            $display("FAIL len_max: done=%b writes=%0d required 1/1024", done, got_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 1024; i++)
                if (got_addr[i] !== 32'(i * 4) || got_data[i] !== exp_words[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL len_max_data: bad_words=%0d required 0 (last addr %h, required 00000ffc)",
                         bad, got_addr[1023]);
            end
        end
        pulse_boot();
    endtask

    task automatic test_gaps();
        int bad = 0;
        clear_capture();
        ready_drop = 0;
        exp_words.delete();
        for (int i = 0; i < 8; i++) exp_words.push_back(32'($urandom()));
        send_body(50);
        send_byte(model_csum());
        checks++;
        if (got_addr.size() != 8 || done !== 1'b1) begin
            errors++;
            $display("FAIL gaps_count: writes=%0d done=%b required 8/1", got_addr.size(), done);
        end else begin
            for (int i = 0; i < 8; i++)
                if (got_addr[i] !== 32'(i * 4) || got_data[i] !== exp_words[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL gaps_data: bad_words=%0d required 0", bad);
            end
        end
        checks++;
        if (ready_drop != 0) begin
            errors++;
            $display("FAIL write_ready: in_ready low in %0d write cycles, required 0", ready_drop);
        end
        pulse_boot();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0;
        clear_capture();
        w0 = 32'($urandom()) | 32'h1;
        send_byte(BOOT_MAGIC); send_byte(8'h02); send_byte(8'h00);
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8]);
        send_byte(8'h11); send_byte(8'h22);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_w_enb, core_rst, done, error} !== 5'b00100
            || mem_addr !== 32'd0 || mem_w_data !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: flags=%b addr=%h data=%h required 00100/0/0",
                     {in_ready, mem_w_enb, core_rst, done, error}, mem_addr, mem_w_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_capture();
        exp_words = '{32'($urandom()), 32'($urandom())};
        send_body(0);
        send_byte(model_csum());
        checks++;
        if (got_addr.size() != 2 || got_addr[0] !== 32'd0 || got_data[0] !== exp_words[0]
            || got_addr[1] !== 32'd4 || got_data[1] !== exp_words[1] || done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: writes=%0d done=%b required 2 writes from addr 0, done=1",
                     got_addr.size(), done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_garbage();
        test_bad_csum();
        test_length();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
